instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-issue MIPS core. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word plus PC+4 into the IF/ID pipeline register. Supports stall, redirect (branch/jump resolved downstream), and a sticky fault halt on bad fetch addresses. The downstream decode stage consumes the IF/ID outputs directly.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_WORDS, 256, number of 32-bit words in instruction memory; legal word index 0..IMEM_WORDS-1.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  reset, asynchronous and active-high.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid  in  1  redirect fetch to redirect_pc; squashes IF/ID.
- redirect_pc  in  32  byte address of redirect target.
- imem_addr  out  32  word index to instruction memory, = {2'b00, pc[31:2]}.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- pc  out  32  current fetch PC (byte address).
- ifid_instr  out  32  registered instruction.
- ifid_pc4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_predicted  out  1  instruction was a J already followed by fetch.
- fault  out  1  sticky: fetch halted on illegal address.
- fetch_count  out  32  instructions delivered since reset (wraps at 2^32).

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, ifid_predicted=0, fault=0, fetch_count=0.
- RUN, per cycle, priority redirect_valid > stall > sequential:
  - redirect_valid=1: pc<=redirect_pc; ifid_valid<=0, ifid_instr<=0 (NOP), ifid_predicted<=0. Overrides a simultaneous stall.
  - stall=1: pc and all IF/ID outputs hold; fetch_count holds.
  - otherwise: ifid_instr<=imem_instr, ifid_pc4<=pc+4, ifid_valid<=1, fetch_count+=1, pc<=next_pc (pc+4, or predecode target, see Configuration).
- Legality: an address is illegal if [1:0]!=0 or [31:2]>=IMEM_WORDS. Checked on the value about to be loaded into pc (redirect_pc or next_pc). If illegal: pc holds, state->HALT, fault<=1; in that same cycle the current instruction is still delivered in the sequential case.
- HALT: pc frozen, ifid_valid<=0, ifid_instr<=0, fetch_count frozen, fault=1; stall and redirect ignored. Only reset leaves HALT.
- PC arithmetic is 32-bit modulo; overflow past IMEM_WORDS is caught by the legality rule.

## Timing
- imem_addr is combinational from the pc register; no read latency assumed.
- Fetch-to-IF/ID latency: 1 cycle; throughput 1 instruction/cycle when not stalled.
- Redirect: target instruction appears in IF/ID 2 edges after redirect_valid is sampled (1 bubble with ifid_valid=0).
- Reset asserted mid-operation clears all state asynchronously, independent of clk; first fetch from RESET_PC on the first edge after deassertion.

## Configuration
- IFETCH_JUMP_PREDECODE_EN defined: if imem_instr[31:26]==6'b000010 (J) in a sequential advance, next_pc={pc4[31:28], imem_instr[25:0], 2'b00} and ifid_predicted<=1 for that instruction; saves the redirect bubble. Legality rule applies to the target.
- Not defined: next_pc is always pc+4; ifid_predicted is constant 0; J is resolved downstream via redirect.

## Test plan
- Reset with RESET_PC=0, imem preloaded 8C010000, 8C020004, 00221820: release reset, run 3 cycles -> ifid_instr sequence 8C010000/8C020004/00221820, ifid_pc4 4/8/C, fetch_count=3.
- Stall held 2 cycles after first fetch -> pc=4, ifid_instr=8C010000 and fetch_count=1 held; resumes with 8C020004.
- redirect_valid with redirect_pc=0x18 while stall=1 -> next cycle ifid_valid=0, pc=0x18; following cycle ifid_instr=imem[6], ifid_pc4=0x1C.
- redirect_pc=0x0000_0402 -> fault=1, ifid_valid=0 and pc frozen; later redirect to 0 ignored; reset clears fault, pc=0.
- Sequential run to word 255 with IMEM_WORDS=256 -> word 255 delivered, then fault=1, pc=0x3FC held.
- J 0 (08000000) at word 7: with IFETCH_JUMP_PREDECODE_EN, pc=0 the cycle after fetch, ifid_predicted=1, no bubble; without it, pc=0x20 and ifid_predicted=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and sticky fault halt.
// Optional J predecode is enabled by defining IFETCH_JUMP_PREDECODE_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        ifid_predicted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  RUN   = 1'b0;
    localparam logic [0:0]  HALT  = 1'b1;
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS);

    logic [0:0]  state;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        is_jump;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < LIMIT);
    endfunction

    assign imem_addr = {2'b00, pc[31:2]};

    always_comb begin
        pc_plus4 = pc + 32'd4;
`ifdef IFETCH_JUMP_PREDECODE_EN
        is_jump  = (imem_instr[31:26] == 6'b000010);
        next_pc  = is_jump ? {pc_plus4[31:28], imem_instr[25:0], 2'b00} : pc_plus4;
`else
        is_jump  = 1'b0;
        next_pc  = pc_plus4;
`endif
    end

    // An illegal target never reaches pc: pc keeps its last legal value and the stage halts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            ifid_instr     <= 32'h0;
            ifid_pc4       <= 32'h0;
            ifid_valid     <= 1'b0;
            ifid_predicted <= 1'b0;
            fault          <= 1'b0;
            fetch_count    <= 32'h0;
        end else if (state == HALT) begin
            ifid_valid     <= 1'b0;
            ifid_instr     <= 32'h0;
            ifid_predicted <= 1'b0;
        end else if (redirect_valid) begin
            ifid_valid     <= 1'b0;
            ifid_instr     <= 32'h0;
            ifid_predicted <= 1'b0;
            if (addr_legal(redirect_pc)) begin
                pc <= redirect_pc;
            end else begin
                state <= HALT;
                fault <= 1'b1;
            end
        end else if (!stall) begin
            ifid_instr     <= imem_instr;
            ifid_pc4       <= pc_plus4;
            ifid_valid     <= 1'b1;
            ifid_predicted <= is_jump;
            fetch_count    <= fetch_count + 32'd1;
            if (addr_legal(next_pc)) begin
                pc <= next_pc;
            end else begin
                state <= HALT;
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational 256-word instruction memory.
// Expectations for the J case follow IFETCH_JUMP_PREDECODE_EN when it is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        ifid_predicted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] imem [0:255];
    int checks   = 0;
    int failures = 0;

    instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .ifid_predicted (ifid_predicted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb imem_instr = (imem_addr < 32'd256) ? imem[imem_addr[7:0]] : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        checks++;
        if (pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_ifid actual=%b/%h/%h expected=0/00000000/00000000", ifid_valid, ifid_instr, ifid_pc4);
        end
        checks++;
        if (fault !== 1'b0 || fetch_count !== 32'h0 || ifid_predicted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status actual=%b/%h/%b expected=0/00000000/0", fault, fetch_count, ifid_predicted);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [0:2];
        exp_instr[0] = 32'h8C01_0000;
        exp_instr[1] = 32'h8C02_0004;
        exp_instr[2] = 32'h0022_1820;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifid_instr !== exp_instr[i] || ifid_pc4 !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL seq_fetch%0d actual=%h/%h/%b expected=%h/%h/1", i, ifid_instr, ifid_pc4, ifid_valid, exp_instr[i], 32'(4 * (i + 1)));
            end
        end
        checks++;
        if (fetch_count !== 32'd3 || pc !== 32'hC) begin
            failures++;
            $display("[TB] FAIL seq_count actual=%0d/%h expected=3/0000000c", fetch_count, pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== 32'h4 || ifid_instr !== 32'h8C01_0000 || fetch_count !== 32'd1) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d actual=%h/%h/%0d expected=00000004/8c010000/1", i, pc, ifid_instr, fetch_count);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (ifid_instr !== 32'h8C02_0004 || ifid_pc4 !== 32'h8 || fetch_count !== 32'd2) begin
            failures++;
            $display("[TB] FAIL stall_resume actual=%h/%h/%0d expected=8c020004/00000008/2", ifid_instr, ifid_pc4, fetch_count);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h18;
        tick();
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || pc !== 32'h18 || imem_addr !== 32'h6) begin
            failures++;
            $display("[TB] FAIL redirect_bubble actual=%b/%h/%h/%h expected=0/00000000/00000018/00000006", ifid_valid, ifid_instr, pc, imem_addr);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (ifid_instr !== 32'h2004_0006 || ifid_pc4 !== 32'h1C || ifid_valid !== 1'b1 || fetch_count !== 32'd3) begin
            failures++;
            $display("[TB] FAIL redirect_target actual=%h/%h/%b/%0d expected=20040006/0000001c/1/3", ifid_instr, ifid_pc4, ifid_valid, fetch_count);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0402;
        tick();
        checks++;
        if (fault !== 1'b1 || ifid_valid !== 1'b0 || pc !== 32'h1C) begin
            failures++;
            $display("[TB] FAIL fault_set actual=%b/%b/%h expected=1/0/0000001c", fault, ifid_valid, pc);
        end
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (fault !== 1'b1 || pc !== 32'h1C || ifid_valid !== 1'b0 || fetch_count !== 32'd3) begin
            failures++;
            $display("[TB] FAIL fault_sticky actual=%b/%h/%b/%0d expected=1/0000001c/0/3", fault, pc, ifid_valid, fetch_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fault !== 1'b0 || pc !== 32'h0 || fetch_count !== 32'h0) begin
            failures++;
            $display("[TB] FAIL fault_async_reset actual=%b/%h/%0d expected=0/00000000/0", fault, pc, fetch_count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_end_of_memory();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3F0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ifid_instr !== 32'hA000_00FF || ifid_pc4 !== 32'h400 || ifid_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL end_last_word actual=%h/%h/%b expected=a00000ff/00000400/1", ifid_instr, ifid_pc4, ifid_valid);
        end
        checks++;
        if (fault !== 1'b1 || pc !== 32'h3FC || fetch_count !== 32'd4) begin
            failures++;
            $display("[TB] FAIL end_fault actual=%b/%h/%0d expected=1/000003fc/4", fault, pc, fetch_count);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b0 || pc !== 32'h3FC || fetch_count !== 32'd4) begin
            failures++;
            $display("[TB] FAIL end_halted actual=%b/%h/%0d expected=0/000003fc/4", ifid_valid, pc, fetch_count);
        end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc;
        logic        exp_pred;
        logic [31:0] exp_next_instr;
        logic [31:0] exp_next_pc4;
`ifdef IFETCH_JUMP_PREDECODE_EN
        exp_pc = 32'h0;
        exp_pred = 1'b1;
        exp_next_instr = 32'h8C01_0000;
        exp_next_pc4 = 32'h4;
`else
        exp_pc = 32'h20;
        exp_pred = 1'b0;
        exp_next_instr = 32'h0;
        exp_next_pc4 = 32'h24;
`endif
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (ifid_instr !== 32'h0800_0000 || ifid_pc4 !== 32'h20 || pc !== exp_pc || ifid_predicted !== exp_pred) begin
            failures++;
            $display("[TB] FAIL jump_fetch actual=%h/%h/%h/%b expected=08000000/00000020/%h/%b", ifid_instr, ifid_pc4, pc, ifid_predicted, exp_pc, exp_pred);
        end
        tick();
        checks++;
        if (ifid_instr !== exp_next_instr || ifid_pc4 !== exp_next_pc4 || ifid_valid !== 1'b1 || ifid_predicted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_follow actual=%h/%h/%b/%b expected=%h/%h/1/0", ifid_instr, ifid_pc4, ifid_valid, ifid_predicted, exp_next_instr, exp_next_pc4);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0] = 32'h8C01_0000;
        imem[1] = 32'h8C02_0004;
        imem[2] = 32'h0022_1820;
        imem[6] = 32'h2004_0006;
        imem[7] = 32'h0800_0000;
        for (int i = 252; i < 256; i++) imem[i] = 32'hA000_0000 | 32'(i);

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault();
        test_end_of_memory();
        test_jump();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
